// File: rtl/rrf_alloc_ctrl.sv
// ============================================================================
// Module      : rrf_alloc_ctrl
// Description : In-order rename-tag allocator for a dual-issue decode stage.
//               Slot A (older) has priority over slot B (younger), and tags
//               are retired in order. The optional RRF_ALLOC_STATS_EN macro
//               enables the allocation-stall cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rrf_alloc_ctrl #(
  parameter int RRF_DEPTH  = 16,
  parameter int TAG_W      = 4,
  parameter int ARF_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  map_en_A,
  input  logic                  map_en_B,
  input  logic [ARF_ADDR_W-1:0] wraddrA_map,
  input  logic [ARF_ADDR_W-1:0] wraddrB_map,
  input  logic                  updateEnA,
  input  logic                  updateEnB,
  input  logic                  flush,
  output logic [TAG_W-1:0]      tagA,
  output logic [TAG_W-1:0]      tagB,
  output logic                  grantA,
  output logic                  grantB,
  output logic                  wrA_rrError,
  output logic                  wrB_rrError,
  output logic [TAG_W:0]        free_cnt,
  output logic [31:0]           stall_cnt
);

  localparam logic [TAG_W:0] c_depth = (TAG_W+1)'(RRF_DEPTH);
  localparam logic [TAG_W:0] c_one   = (TAG_W+1)'(1);
  localparam logic [TAG_W:0] c_two   = (TAG_W+1)'(2);

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic             w_req_a;
  logic             w_req_b;
  logic             w_grant_a;
  logic             w_grant_b;
  logic [TAG_W:0]   w_free;
  logic [TAG_W:0]   w_need_b;
  logic [TAG_W:0]   w_nalloc;
  logic [TAG_W:0]   w_ret_req;
  logic [TAG_W:0]   w_nret;

  assign w_req_a = map_en_A & (wraddrA_map != '0);
  assign w_req_b = map_en_B & (wraddrB_map != '0);

  // Grants see only the registered occupancy; same-cycle retires do not bypass.
  assign w_free    = c_depth - r_count;
  assign w_need_b  = w_req_a ? c_two : c_one;
  assign w_grant_a = w_req_a & ~flush & (w_free >= c_one);
  assign w_grant_b = w_req_b & ~flush & ~(w_req_a & ~w_grant_a) & (w_free >= w_need_b);

  assign w_nalloc  = (TAG_W+1)'(w_grant_a) + (TAG_W+1)'(w_grant_b);
  // A lone updateEnB is treated as one retire; retires never exceed live tags.
  assign w_ret_req = (TAG_W+1)'(updateEnA | updateEnB) + (TAG_W+1)'(updateEnA & updateEnB);
  assign w_nret    = (w_ret_req > r_count) ? r_count : w_ret_req;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_nret[TAG_W-1:0];
      r_tail  <= r_tail + w_nalloc[TAG_W-1:0];
      r_count <= r_count + w_nalloc - w_nret;
    end
  end

  assign tagA        = r_tail;
  assign tagB        = w_req_a ? (r_tail + TAG_W'(1)) : r_tail;
  assign grantA      = w_grant_a;
  assign grantB      = w_grant_b;
  assign wrA_rrError = w_req_a & ~w_grant_a;
  assign wrB_rrError = w_req_b & ~w_grant_b;
  assign free_cnt    = w_free;

`ifdef RRF_ALLOC_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((wrA_rrError | wrB_rrError) && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rrf_alloc_ctrl.sv
// ============================================================================
// Module      : tb_rrf_alloc_ctrl
// Description : Directed self-checking bench for rrf_alloc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rrf_alloc_ctrl;

  logic        clk;
  logic        rst;
  logic        map_en_A, map_en_B;
  logic [4:0]  wraddrA_map, wraddrB_map;
  logic        updateEnA, updateEnB, flush;
  logic [3:0]  tagA, tagB;
  logic        grantA, grantB, wrA_rrError, wrB_rrError;
  logic [4:0]  free_cnt;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  rrf_alloc_ctrl #(.RRF_DEPTH(16), .TAG_W(4), .ARF_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .map_en_A(map_en_A), .map_en_B(map_en_B),
    .wraddrA_map(wraddrA_map), .wraddrB_map(wraddrB_map),
    .updateEnA(updateEnA), .updateEnB(updateEnB), .flush(flush),
    .tagA(tagA), .tagB(tagB), .grantA(grantA), .grantB(grantB),
    .wrA_rrError(wrA_rrError), .wrB_rrError(wrB_rrError),
    .free_cnt(free_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    map_en_A = 0; map_en_B = 0; wraddrA_map = 0; wraddrB_map = 0;
    updateEnA = 0; updateEnB = 0; flush = 0;
  endtask

  task automatic drive(input logic ea, input logic [4:0] ra, input logic eb, input logic [4:0] rb,
                       input logic ua, input logic ub, input logic fl);
    map_en_A = ea; wraddrA_map = ra; map_en_B = eb; wraddrB_map = rb;
    updateEnA = ua; updateEnB = ub; flush = fl;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (free_cnt !== 5'd16) begin bad++; $display("FAIL reset_free got=%0d exp=16", free_cnt); end
    total++; if ({grantA, grantB, wrA_rrError, wrB_rrError} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {grantA, grantB, wrA_rrError, wrB_rrError}); end
    total++; if (tagA !== 4'd0) begin bad++; $display("FAIL reset_tagA got=%0d exp=0", tagA); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic fill_pool(input bit check);
    for (int i = 0; i < 8; i++) begin
      drive(1, 5'd1, 1, 5'd2, 0, 0, 0);
      if (check) begin
        total++; if (tagA !== 4'(2*i) || tagB !== 4'(2*i+1)) begin bad++; $display("FAIL fill_tags[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, tagA, tagB, 2*i, 2*i+1); end
        total++; if (grantA !== 1'b1 || grantB !== 1'b1 || free_cnt !== 5'(16-2*i)) begin bad++; $display("FAIL fill_grant[%0d] got=%b%b free=%0d exp=11 free=%0d", i, grantA, grantB, free_cnt, 16-2*i); end
      end
      tick();
    end
  endtask

  task automatic test_fill();
    fill_pool(1'b1);
    drive(1, 5'd1, 1, 5'd2, 0, 0, 0);
    total++; if (wrA_rrError !== 1'b1 || wrB_rrError !== 1'b1) begin bad++; $display("FAIL full_errors got=%b%b exp=11", wrA_rrError, wrB_rrError); end
    total++; if (free_cnt !== 5'd0 || grantA !== 1'b0 || grantB !== 1'b0) begin bad++; $display("FAIL full_state free=%0d grants=%b%b exp free=0 grants=00", free_cnt, grantA, grantB); end
    idle();
  endtask

  task automatic test_full_retire();
    drive(1, 5'd3, 0, 5'd0, 1, 0, 0);
    total++; if (wrA_rrError !== 1'b1 || grantA !== 1'b0) begin bad++; $display("FAIL no_bypass err=%b grant=%b exp err=1 grant=0", wrA_rrError, grantA); end
    tick();
    drive(1, 5'd3, 0, 5'd0, 0, 0, 0);
    total++; if (grantA !== 1'b1 || tagA !== 4'd0 || free_cnt !== 5'd1) begin bad++; $display("FAIL wrap_grant grant=%b tag=%0d free=%0d exp 1/0/1", grantA, tagA, free_cnt); end
    tick();
    idle(); #1;
    total++; if (free_cnt !== 5'd0) begin bad++; $display("FAIL wrap_refull free=%0d exp=0", free_cnt); end
  endtask

  task automatic test_partial();
    // head=1 tail=1 count=16; retire one leaves a single free tag at 1
    drive(0, 5'd0, 0, 5'd0, 1, 0, 0);
    tick();
    drive(1, 5'd4, 1, 5'd5, 0, 0, 0);
    total++; if (grantA !== 1'b1 || tagA !== 4'd1 || wrA_rrError !== 1'b0) begin bad++; $display("FAIL one_free_A grant=%b tag=%0d err=%b exp 1/1/0", grantA, tagA, wrA_rrError); end
    total++; if (grantB !== 1'b0 || wrB_rrError !== 1'b1) begin bad++; $display("FAIL one_free_B grant=%b err=%b exp 0/1", grantB, wrB_rrError); end
    drive(1, 5'd0, 1, 5'd5, 0, 0, 0);
    total++; if (grantB !== 1'b1 || tagB !== 4'd1 || grantA !== 1'b0 || wrA_rrError !== 1'b0) begin bad++; $display("FAIL rd0_slotB grantB=%b tagB=%0d grantA=%b errA=%b exp 1/1/0/0", grantB, tagB, grantA, wrA_rrError); end
    tick();
    drive(0, 5'd0, 0, 5'd0, 1, 1, 0);
    total++; if (free_cnt !== 5'd0) begin bad++; $display("FAIL refull_free free=%0d exp=0", free_cnt); end
    tick();
    drive(0, 5'd0, 0, 5'd0, 0, 1, 0);
    total++; if (free_cnt !== 5'd2) begin bad++; $display("FAIL dual_retire free=%0d exp=2", free_cnt); end
    tick();
    idle(); #1;
    total++; if (free_cnt !== 5'd3) begin bad++; $display("FAIL lone_B_retire free=%0d exp=3", free_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 5'd1, 1, 5'd2, 0, 0, 0); tick();
    drive(1, 5'd1, 1, 5'd2, 0, 0, 0); tick();
    drive(1, 5'd1, 0, 5'd0, 0, 0, 0); tick();
    drive(1, 5'd6, 0, 5'd0, 1, 0, 1);
    total++; if (free_cnt !== 5'd11 || wrA_rrError !== 1'b1 || grantA !== 1'b0) begin bad++; $display("FAIL flush_cycle free=%0d err=%b grant=%b exp 11/1/0", free_cnt, wrA_rrError, grantA); end
    tick();
    idle(); #1;
    total++; if (free_cnt !== 5'd16 || tagA !== 4'd0) begin bad++; $display("FAIL after_flush free=%0d tag=%0d exp 16/0", free_cnt, tagA); end
    drive(0, 5'd0, 0, 5'd0, 1, 1, 0); tick();
    idle(); #1;
    total++; if (free_cnt !== 5'd16) begin bad++; $display("FAIL empty_retire free=%0d exp=16", free_cnt); end
    drive(1, 5'd7, 0, 5'd0, 0, 0, 0); tick();
    drive(0, 5'd0, 0, 5'd0, 1, 1, 0); tick();
    drive(1, 5'd7, 0, 5'd0, 0, 0, 0);
    total++; if (free_cnt !== 5'd16 || tagA !== 4'd1 || grantA !== 1'b1) begin bad++; $display("FAIL clamp_retire free=%0d tag=%0d grant=%b exp 16/1/1", free_cnt, tagA, grantA); end
    tick();
  endtask

  task automatic test_back_to_back();
    // count=1 tail=2: allocate two while retiring two (one clamps away)
    drive(1, 5'd1, 1, 5'd2, 1, 1, 0);
    total++; if (tagA !== 4'd2 || tagB !== 4'd3 || grantA !== 1'b1 || grantB !== 1'b1) begin bad++; $display("FAIL b2b_tags got=(%0d,%0d) grants=%b%b exp (2,3) 11", tagA, tagB, grantA, grantB); end
    tick();
    drive(1, 5'd1, 1, 5'd2, 1, 1, 0);
    total++; if (free_cnt !== 5'd14 || tagA !== 4'd4) begin bad++; $display("FAIL b2b_mid free=%0d tag=%0d exp 14/4", free_cnt, tagA); end
    tick();
    idle(); #1;
    total++; if (free_cnt !== 5'd14 || tagA !== 4'd6) begin bad++; $display("FAIL b2b_end free=%0d tag=%0d exp 14/6", free_cnt, tagA); end
  endtask

  task automatic test_stats();
    logic [31:0] exp_stall;
`ifdef RRF_ALLOC_STATS_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    do_reset();
    fill_pool(1'b0);
    idle(); #1;
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL stats_pre got=%0d exp=0", stall_cnt); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd1, 1, 5'd2, 0, 0, 0); tick();
    end
    drive(1, 5'd1, 1, 5'd2, 0, 0, 1); tick();
    idle(); #1;
    total++; if (stall_cnt !== exp_stall) begin bad++; $display("FAIL stats_count got=%0d exp=%0d", stall_cnt, exp_stall); end
    do_reset();
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL stats_reset got=%0d exp=0", stall_cnt); end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_fill();
    test_full_retire();
    test_partial();
    test_flush();
    test_back_to_back();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
